// File: rtl/ram_uart_dump.sv
// ram_uart_dump: reads count words from RAM address 0 and sends each as four 8N1 UART bytes, low byte first.
// Optional macro DUMP_HEADER_EN prepends the header bytes A5 5A cnt[15:8] cnt[7:0]; start is ignored while busy.
module ram_uart_dump #(
    parameter int W            = 32,
    parameter int AW           = 14,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   count,
    output logic [AW-1:0] address,
    input  logic [W-1:0]  readdata,
    output logic          tx,
    output logic          busy,
    output logic          done
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int NB = W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [AW:0]   MAX_WORDS = {1'b1, {AW{1'b0}}};
    localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);

`ifdef DUMP_HEADER_EN
    typedef enum logic [2:0] {IDLE, HDR, FETCH, SEND, NEXT, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SEND, NEXT, FIN} state_t;
`endif

    state_t        state;
    logic [AW:0]   cnt;
    logic [AW:0]   words;
    logic [AW:0]   cnt_clamped;
    logic [W-1:0]  sr;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    logic [BW-1:0] byte_idx;
    logic [7:0]    cur_byte;
    logic          frame_bit;
    logic          bit_end;
    logic          frames_end;
    logic          sending;
`ifdef DUMP_HEADER_EN
    logic          hdr_tail;
    logic [15:0]   cnt16;

    assign cnt16   = 16'(cnt_clamped);
    assign sending = (state == SEND) || (state == HDR && !hdr_tail);
`else
    assign sending = (state == SEND);
`endif

    assign cnt_clamped = (count > MAX_WORDS) ? MAX_WORDS : count;
    assign cur_byte    = sr[7:0];
    assign bit_end     = (clk_cnt == LAST_CLK);
    assign frames_end  = bit_end && (bit_idx == 4'd9) && (byte_idx == BW'(NB - 1));

    // bit_idx 0 is the start bit, 1..8 data LSB first, 9 the stop bit
    always_comb begin
        frame_bit = 1'b1;
        if (bit_idx == 4'd0) begin
            frame_bit = 1'b0;
        end else if (bit_idx <= 4'd8) begin
            frame_bit = cur_byte[3'(bit_idx - 4'd1)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            address  <= '0;
            cnt      <= '0;
            words    <= '0;
            sr       <= '0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
`ifdef DUMP_HEADER_EN
            hdr_tail <= 1'b0;
`endif
        end else begin
            // Shared bit engine for header and data frames; tx is registered so it lags the state by one cycle.
            if (sending) begin
                tx <= frame_bit;
                if (bit_end) begin
                    clk_cnt <= '0;
                    if (bit_idx == 4'd9) begin
                        bit_idx  <= '0;
                        sr       <= sr >> 8;
                        byte_idx <= byte_idx + 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end
            end else begin
                tx <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= cnt_clamped;
                        words    <= '0;
                        address  <= '0;
                        busy     <= 1'b1;
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
`ifdef DUMP_HEADER_EN
                        sr       <= W'({cnt16[7:0], cnt16[15:8], 8'h5A, 8'hA5});
                        hdr_tail <= 1'b0;
                        state    <= HDR;
`else
                        if (cnt_clamped == '0) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            state <= FETCH;
                        end
`endif
                    end
                end
`ifdef DUMP_HEADER_EN
                HDR: begin
                    // One extra idle cycle after the header keeps the same 2-cycle gap before data.
                    if (hdr_tail) begin
                        hdr_tail <= 1'b0;
                        if (cnt == '0) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (frames_end) begin
                        hdr_tail <= 1'b1;
                    end
                end
`endif
                FETCH: begin
                    sr       <= readdata;
                    byte_idx <= '0;
                    bit_idx  <= '0;
                    clk_cnt  <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (frames_end) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    words <= words + (AW+1)'(1);
                    if (words + (AW+1)'(1) == cnt) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        address <= address + 1'b1;
                        state   <= FETCH;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_uart_dump.sv
// Bench for ram_uart_dump: table of dump runs decoded from tx, plus reset sequences.
module tb_ram_uart_dump;
    localparam int AW = 4;
    localparam int W  = 32;
    localparam int C  = 4;
`ifdef DUMP_HEADER_EN
    localparam int HB       = 4;
    localparam int HDR_CYC  = 40 * C + 1;
    localparam int FIRST_TX = 1;
`else
    localparam int HB       = 0;
    localparam int HDR_CYC  = 0;
    localparam int FIRST_TX = 2;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   count = '0;
    logic [AW-1:0] address;
    logic [W-1:0]  readdata;
    logic          tx;
    logic          busy;
    logic          done;

    logic [W-1:0] ram [16];
    assign readdata = ram[address];

    ram_uart_dump #(.W(W), .AW(AW), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .address(address),
        .readdata(readdata), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // UART receiver: samples mid-bit on falling clock edges
    logic [7:0] rx_q [$];
    int         ts_q [$];
    int         ad_q [$];
    int         ferr = 0;

    initial begin
        logic [7:0] rb;
        int rt, ra;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                rt = cyc;
                ra = int'(address);
                repeat (C / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (C) @(negedge clk);
                    rb[k] = tx;
                end
                repeat (C) @(negedge clk);
                if (tx !== 1'b1) ferr++;
                rx_q.push_back(rb);
                ts_q.push_back(rt);
                ad_q.push_back(ra);
            end
        end
    end

    typedef struct {
        logic [AW:0] cnt;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          glitch;
        int          exp_words;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int vi);
        vec_t       v;
        int         t0, t_done, t_busy, n_done, k;
        logic [7:0] exp_b [$];
        logic [31:0] wd;
        v = vecs[vi];
        for (int i = 0; i < 16; i++) ram[i] = {8'hC0, 4'h0, 4'(i), 8'h3C ^ 8'(i), 8'(i * 7)};
        ram[0] = v.w0;
        ram[1] = v.w1;
        ram[2] = v.w2;
        rx_q.delete(); ts_q.delete(); ad_q.delete(); ferr = 0;

        @(negedge clk);
        start = 1'b1;
        count = v.cnt;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        check($sformatf("v%0d busy_after_start", vi), busy, 1);
        check($sformatf("v%0d addr_after_start", vi), address, 0);

        t_done = -1; t_busy = -1; n_done = 0; k = 0;
        while (t_busy < 0 && k < 6000) begin
            if (done === 1'b1) begin
                n_done++;
                if (t_done < 0) t_done = cyc - t0;
            end
            if (busy === 1'b0) begin
                t_busy = cyc - t0;
            end else begin
                start = (v.glitch > 0 && cyc - t0 == v.glitch);
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        check($sformatf("v%0d done_cycle", vi), t_done, v.exp_done + HDR_CYC);
        check($sformatf("v%0d busy_fall_cycle", vi), t_busy, v.exp_done + HDR_CYC + 1);
        check($sformatf("v%0d done_pulses", vi), n_done, 1);
        check($sformatf("v%0d final_addr", vi), address, (v.exp_words == 0) ? 0 : v.exp_words - 1);
        repeat (4) @(negedge clk);
        check($sformatf("v%0d tx_idle", vi), tx, 1);

`ifdef DUMP_HEADER_EN
        exp_b.push_back(8'hA5);
        exp_b.push_back(8'h5A);
        exp_b.push_back(8'(v.exp_words >> 8));
        exp_b.push_back(8'(v.exp_words));
`endif
        for (int i = 0; i < v.exp_words; i++) begin
            wd = ram[i];
            for (int b = 0; b < 4; b++) exp_b.push_back(wd[8*b +: 8]);
        end
        check($sformatf("v%0d byte_count", vi), rx_q.size(), exp_b.size());
        check($sformatf("v%0d stop_bit_errors", vi), ferr, 0);
        for (int i = 0; i < rx_q.size() && i < exp_b.size(); i++) begin
            check($sformatf("v%0d byte%0d", vi, i), rx_q[i], exp_b[i]);
            check($sformatf("v%0d addr_at_byte%0d", vi, i), ad_q[i], (i < HB) ? 0 : (i - HB) / 4);
        end
        if (ts_q.size() > 0) check($sformatf("v%0d first_start_bit", vi), ts_q[0] - t0, FIRST_TX);
        for (int i = 1; i < ts_q.size(); i++) begin
            check($sformatf("v%0d gap%0d", vi, i), ts_q[i] - ts_q[i-1], (i % 4 == 0) ? 10 * C + 2 : 10 * C);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        vecs[0] = '{cnt: 5'd1,  w0: 32'h12345678, w1: 32'h0, w2: 32'h0, glitch: 0,  exp_words: 1,  exp_done: 162};
        vecs[1] = '{cnt: 5'd3,  w0: 32'h00000001, w1: 32'h00000002, w2: 32'h00000003, glitch: 0, exp_words: 3, exp_done: 486};
        vecs[2] = '{cnt: 5'd0,  w0: 32'hFFFFFFFF, w1: 32'h0, w2: 32'h0, glitch: 0,  exp_words: 0,  exp_done: 0};
        vecs[3] = '{cnt: 5'd21, w0: 32'hA5A5A5A5, w1: 32'h80000001, w2: 32'h7E00FF81, glitch: 0, exp_words: 16, exp_done: 2592};
        vecs[4] = '{cnt: 5'd2,  w0: 32'hDEADBEEF, w1: 32'h0055AA01, w2: 32'h0, glitch: 55, exp_words: 2, exp_done: 324};
        vecs[5] = '{cnt: 5'd16, w0: 32'h00000000, w1: 32'hFFFFFFFF, w2: 32'h01020304, glitch: 0, exp_words: 16, exp_done: 2592};
        for (int i = 0; i < 16; i++) ram[i] = '0;

        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset address", address, 0);
        rst = 1'b0;

        // Reset in the middle of the first byte frame
        ram[0] = 32'h12345678;
        @(negedge clk);
        start = 1'b1;
        count = 5'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst tx", tx, 1);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst address", address, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("midrst no_done", nd, 0);
        check("midrst busy_after", busy, 0);

        for (int vi = 0; vi < 6; vi++) run_vec(vi);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
